// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers for the RV32I core: memory-wait stall,
// M-stage flush, per-stage valid bits, writeback select and retired counter.
module ex_mem_wb_pipe #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StallM,
   input  logic             FlushM,
   input  logic             ValidE,
   input  logic             RegWriteE,
   input  logic [1:0]       ResultSrcE,
   input  logic             MemWriteE,
   input  logic [4:0]       RdE,
   input  logic [XLEN-1:0]  ALUResultE,
   input  logic [XLEN-1:0]  WriteDataE,
   input  logic [XLEN-1:0]  PCPlus4E,
   input  logic [XLEN-1:0]  ReadDataM,
   output logic             ValidM,
   output logic             RegWriteM,
   output logic [1:0]       ResultSrcM,
   output logic             MemWriteM,
   output logic [4:0]       RdM,
   output logic [XLEN-1:0]  ALUResultM,
   output logic [XLEN-1:0]  WriteDataM,
   output logic             ValidW,
   output logic             RegWriteW,
   output logic [4:0]       RdW,
   output logic [XLEN-1:0]  ResultW,
   output logic [CNT_W-1:0] RetiredCount
);

   logic [XLEN-1:0] r_PCPlus4M;
   logic [1:0]      r_ResultSrcW;
   logic [XLEN-1:0] r_ALUResultW;
   logic [XLEN-1:0] r_PCPlus4W;
   logic [XLEN-1:0] r_ReadDataW;

   always_ff @(posedge clk) begin
      if (reset) begin
         ValidM       <= 1'b0;
         RegWriteM    <= 1'b0;
         ResultSrcM   <= 2'b00;
         MemWriteM    <= 1'b0;
         RdM          <= '0;
         ALUResultM   <= '0;
         WriteDataM   <= '0;
         r_PCPlus4M   <= '0;
         ValidW       <= 1'b0;
         RegWriteW    <= 1'b0;
         RdW          <= '0;
         r_ResultSrcW <= 2'b00;
         r_ALUResultW <= '0;
         r_PCPlus4W   <= '0;
         r_ReadDataW  <= '0;
         RetiredCount <= '0;
      end else begin
         if (!StallM) begin
            // A flushed slot keeps its stale data; only control fields are killed.
            if (FlushM) begin
               ValidM     <= 1'b0;
               RegWriteM  <= 1'b0;
               MemWriteM  <= 1'b0;
               RdM        <= '0;
               ResultSrcM <= 2'b00;
            end else begin
               ValidM     <= ValidE;
               RegWriteM  <= RegWriteE & ValidE & (RdE != 5'd0);
               MemWriteM  <= MemWriteE & ValidE;
               RdM        <= RdE;
               ResultSrcM <= ResultSrcE;
               ALUResultM <= ALUResultE;
               WriteDataM <= WriteDataE;
               r_PCPlus4M <= PCPlus4E;
            end
            ValidW       <= ValidM;
            RegWriteW    <= RegWriteM;
            RdW          <= RdM;
            r_ResultSrcW <= ResultSrcM;
            r_ALUResultW <= ALUResultM;
            r_PCPlus4W   <= r_PCPlus4M;
            r_ReadDataW  <= ReadDataM;
         end else begin
            // M is held, so W must not see the same instruction twice.
            ValidW    <= 1'b0;
            RegWriteW <= 1'b0;
            RdW       <= '0;
         end
         if (ValidW)
            RetiredCount <= RetiredCount + CNT_W'(1);
      end
   end

   always_comb begin
      ResultW = '0;
      case (r_ResultSrcW)
         2'b00:   ResultW = r_ALUResultW;
         2'b01:   ResultW = r_ReadDataW;
         2'b10:   ResultW = r_PCPlus4W;
         default: ResultW = '0;
      endcase
   end

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Scoreboarded bench for ex_mem_wb_pipe (small counter width to exercise wrap).
module tb_ex_mem_wb_pipe;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset, StallM, FlushM, ValidE, RegWriteE, MemWriteE;
   logic [1:0]       ResultSrcE;
   logic [4:0]       RdE;
   logic [XLEN-1:0]  ALUResultE, WriteDataE, PCPlus4E, ReadDataM;
   logic             ValidM, RegWriteM, MemWriteM, ValidW, RegWriteW;
   logic [1:0]       ResultSrcM;
   logic [4:0]       RdM, RdW;
   logic [XLEN-1:0]  ALUResultM, WriteDataM, ResultW;
   logic [CNT_W-1:0] RetiredCount;

   typedef struct packed {
      logic            rw;
      logic [4:0]      rd;
      logic [XLEN-1:0] res;
   } wb_t;

   wb_t              q[$];
   logic [CNT_W-1:0] exp_cnt = '0;
   int               checks = 0;
   int               errors = 0;

   ex_mem_wb_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM),
      .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
      .MemWriteE(MemWriteE), .RdE(RdE), .ALUResultE(ALUResultE),
      .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .ReadDataM(ReadDataM),
      .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
      .MemWriteM(MemWriteM), .RdM(RdM), .ALUResultM(ALUResultM),
      .WriteDataM(WriteDataM), .ValidW(ValidW), .RegWriteW(RegWriteW),
      .RdW(RdW), .ResultW(ResultW), .RetiredCount(RetiredCount)
   );

   always #5 clk = ~clk;

   // Retirement monitor: every valid W slot must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         if (RetiredCount !== exp_cnt) begin
            errors++;
            $display("FAIL retired_count: got %0d expected %0d", RetiredCount, exp_cnt);
         end
         if (ValidW === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL retire_unexpected: rd=%0d res=%h with empty scoreboard", RdW, ResultW);
            end else begin
               wb_t e;
               e = q.pop_front();
               if ({RegWriteW, RdW, ResultW} !== e) begin
                  errors++;
                  $display("FAIL retire_data: got rw=%b rd=%0d res=%h expected rw=%b rd=%0d res=%h",
                           RegWriteW, RdW, ResultW, e.rw, e.rd, e.res);
               end
            end
            exp_cnt = exp_cnt + 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_e();
      ValidE = 0; RegWriteE = 0; ResultSrcE = 2'b00; MemWriteE = 0; RdE = '0;
      ALUResultE = '0; WriteDataE = '0; PCPlus4E = '0;
   endtask

   // Drive one instruction into E; push its writeback expectation unless flushed.
   task automatic drive_e(input logic rw, input logic [1:0] src, input logic mw,
                          input logic [4:0] rd, input logic [XLEN-1:0] alu,
                          input logic [XLEN-1:0] pc4, input logic [XLEN-1:0] ld,
                          input logic push);
      wb_t e;
      ValidE = 1; RegWriteE = rw; ResultSrcE = src; MemWriteE = mw; RdE = rd;
      ALUResultE = alu; WriteDataE = alu ^ 32'h5A5A_5A5A; PCPlus4E = pc4;
      e.rw  = rw & (rd != 5'd0);
      e.rd  = rd;
      e.res = (src == 2'b00) ? alu : (src == 2'b01) ? ld : (src == 2'b10) ? pc4 : '0;
      if (push) q.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1;
      step();
      reset = 0;
      q.delete();
      exp_cnt = '0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({ValidM, RegWriteM, ResultSrcM, MemWriteM, RdM, ALUResultM, WriteDataM,
           ValidW, RegWriteW, RdW, ResultW, RetiredCount} !== '0) begin
         errors++;
         $display("FAIL reset_state: ValidM=%b RdM=%0d ValidW=%b RdW=%0d ResultW=%h cnt=%0d expected all 0",
                  ValidM, RdM, ValidW, RdW, ResultW, RetiredCount);
      end
   endtask

   task automatic test_add();
      drive_e(1, 2'b00, 0, 5'd5, 32'h10, 32'h4, 32'h0, 1);
      step(); idle_e();
      checks++;
      if ({RdM, RegWriteM, ValidM} !== {5'd5, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL add_m: RdM=%0d RegWriteM=%b ValidM=%b expected 5 1 1", RdM, RegWriteM, ValidM);
      end
      step();
      checks++;
      if ({RdW, RegWriteW, ResultW} !== {5'd5, 1'b1, 32'h10}) begin
         errors++;
         $display("FAIL add_w: RdW=%0d RegWriteW=%b ResultW=%h expected 5 1 00000010", RdW, RegWriteW, ResultW);
      end
      step();
      checks++;
      if (RetiredCount !== 4'd1) begin
         errors++;
         $display("FAIL add_count: got %0d expected 1", RetiredCount);
      end
   endtask

   task automatic test_load_jal();
      drive_e(1, 2'b01, 0, 5'd7, 32'h200, 32'h8, 32'hDEAD_BEEF, 1);
      step(); idle_e();
      ReadDataM = 32'hDEAD_BEEF;
      step();
      ReadDataM = 32'h1234_5678;
      #1;
      checks++;
      if ({ResultW, RegWriteW} !== {32'hDEAD_BEEF, 1'b1}) begin
         errors++;
         $display("FAIL load_w: ResultW=%h RegWriteW=%b expected deadbeef 1", ResultW, RegWriteW);
      end
      drive_e(1, 2'b10, 0, 5'd1, 32'h300, 32'h104, 32'h0, 1);
      step(); idle_e();
      step();
      checks++;
      if (ResultW !== 32'h104) begin
         errors++;
         $display("FAIL jal_w: ResultW=%h expected 00000104", ResultW);
      end
      drive_e(1, 2'b11, 0, 5'd2, 32'h400, 32'h108, 32'h0, 1);
      step(); idle_e();
      step();
      checks++;
      if (ResultW !== 32'h0) begin
         errors++;
         $display("FAIL reserved_src: ResultW=%h expected 00000000", ResultW);
      end
   endtask

   task automatic test_x0();
      drive_e(1, 2'b00, 0, 5'd0, 32'h55, 32'h0, 32'h0, 1);
      step(); idle_e();
      checks++;
      if ({RegWriteM, ValidM} !== 2'b01) begin
         errors++;
         $display("FAIL x0_m: RegWriteM=%b ValidM=%b expected 0 1", RegWriteM, ValidM);
      end
      step();
      checks++;
      if ({RegWriteW, ValidW} !== 2'b01) begin
         errors++;
         $display("FAIL x0_w: RegWriteW=%b ValidW=%b expected 0 1", RegWriteW, ValidW);
      end
      step();
   endtask

   task automatic test_stall();
      drive_e(1, 2'b00, 0, 5'd3, 32'h33, 32'h0, 32'h0, 1);
      step(); idle_e();
      StallM = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if ({RdM, RegWriteM, ALUResultM, RegWriteW, ValidW} !== {5'd3, 1'b1, 32'h33, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold%0d: RdM=%0d RegWriteM=%b ALUResultM=%h RegWriteW=%b ValidW=%b expected 3 1 33 0 0",
                     i, RdM, RegWriteM, ALUResultM, RegWriteW, ValidW);
         end
      end
      StallM = 0;
      step();
      checks++;
      if ({RdW, RegWriteW, ValidW, ResultW} !== {5'd3, 1'b1, 1'b1, 32'h33}) begin
         errors++;
         $display("FAIL stall_release: RdW=%0d RegWriteW=%b ValidW=%b ResultW=%h expected 3 1 1 33",
                  RdW, RegWriteW, ValidW, ResultW);
      end
      step();
      checks++;
      if (ValidW !== 1'b0) begin
         errors++;
         $display("FAIL stall_once: ValidW=%b expected 0", ValidW);
      end
   endtask

   task automatic test_flush();
      drive_e(0, 2'b00, 1, 5'd0, 32'h80, 32'h0, 32'h0, 0);
      FlushM = 1;
      step(); idle_e();
      FlushM = 0;
      checks++;
      if ({MemWriteM, ValidM, RdM, RegWriteM} !== 8'b0) begin
         errors++;
         $display("FAIL flush_bubble: MemWriteM=%b ValidM=%b RdM=%0d RegWriteM=%b expected 0 0 0 0",
                  MemWriteM, ValidM, RdM, RegWriteM);
      end
      drive_e(0, 2'b00, 1, 5'd0, 32'h90, 32'h0, 32'h0, 1);
      step();
      drive_e(1, 2'b00, 0, 5'd9, 32'h99, 32'h0, 32'h0, 0);
      StallM = 1; FlushM = 1;
      step(); idle_e();
      StallM = 0; FlushM = 0;
      checks++;
      if ({ValidM, MemWriteM, ALUResultM} !== {1'b1, 1'b1, 32'h90}) begin
         errors++;
         $display("FAIL stall_over_flush: ValidM=%b MemWriteM=%b ALUResultM=%h expected 1 1 00000090",
                  ValidM, MemWriteM, ALUResultM);
      end
      step(); step();
   endtask

   task automatic test_reset_midflight();
      drive_e(1, 2'b00, 0, 5'd10, 32'hA0, 32'h0, 32'h0, 1);
      step();
      drive_e(1, 2'b00, 0, 5'd11, 32'hB0, 32'h0, 32'h0, 1);
      StallM = 1; FlushM = 1;
      do_reset();
      StallM = 0; FlushM = 0; idle_e();
      checks++;
      if ({ValidM, RegWriteM, RdM, ValidW, RegWriteW, RdW, ResultW, RetiredCount} !== '0) begin
         errors++;
         $display("FAIL reset_midflight: ValidM=%b RdM=%0d ValidW=%b RdW=%0d ResultW=%h cnt=%0d expected all 0",
                  ValidM, RdM, ValidW, RdW, ResultW, RetiredCount);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 15; i++) begin
         drive_e(1, 2'b00, 0, 5'(i + 1), 32'(i * 3), 32'h0, 32'h0, 1);
         step();
      end
      idle_e();
      step(); step(); step();
      checks++;
      if (RetiredCount !== 4'd15) begin
         errors++;
         $display("FAIL wrap_pre: got %0d expected 15", RetiredCount);
      end
      drive_e(1, 2'b00, 0, 5'd20, 32'hF00, 32'h0, 32'h0, 1);
      step(); idle_e();
      step(); step();
      checks++;
      if (RetiredCount !== 4'd0) begin
         errors++;
         $display("FAIL wrap: got %0d expected 0", RetiredCount);
      end
   endtask

   initial begin
      reset = 1; StallM = 0; FlushM = 0; ReadDataM = '0;
      idle_e();
      step();
      test_reset();
      test_add();
      test_load_jal();
      test_x0();
      test_stall();
      test_flush();
      test_reset_midflight();
      test_wrap();
      step();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_mem_wb_pipe.md
Name: ex_mem_wb_pipe

Overview:
- Carries execute-stage results through the EX/MEM and MEM/WB pipeline registers of the pipelined RV32I core.
- Selects the writeback result and drives the register-file write port.
- Supplies RdM, RdW, RegWriteM and RegWriteW to the forwarding/hazard unit, and ALUResultM and ResultW as the forwarding data sources.
- Adds a memory-wait stall, an M-stage flush, per-stage valid bits and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- StallM  in  1  data-memory wait: hold the M stage.
- FlushM  in  1  squash the instruction entering M (bubble).
- ValidE  in  1  E stage holds a real instruction.
- RegWriteE  in  1  instruction writes rd.
- ResultSrcE  in  2  00 ALU, 01 load data, 10 PC+4, 11 reserved.
- MemWriteE  in  1  store.
- RdE  in  5  destination register.
- ALUResultE  in  XLEN  ALU output / memory address.
- WriteDataE  in  XLEN  forwarded store data.
- PCPlus4E  in  XLEN  link value.
- ReadDataM  in  XLEN  data-memory read data, valid in the M cycle.
- ValidM  out  1  M stage holds a real instruction.
- RegWriteM  out  1  to hazard unit.
- ResultSrcM  out  2  to hazard/load-use logic.
- MemWriteM  out  1  data-memory write enable.
- RdM  out  5  to hazard unit.
- ALUResultM  out  XLEN  memory address and forward source (ForwardAE/BE = 10).
- WriteDataM  out  XLEN  data-memory write data.
- ValidW  out  1  W stage holds a real instruction.
- RegWriteW  out  1  register-file write enable, and to hazard unit.
- RdW  out  5  register-file write address, and to hazard unit.
- ResultW  out  XLEN  register-file write data and forward source (ForwardAE/BE = 01).
- RetiredCount  out  CNT_W  count of instructions completed in W.

Behaviour:
- Reset:
  - All registered outputs clear to 0, including every Valid, RegWrite, MemWrite, Rd, data field and RetiredCount.
  - ResultW is 0 because ResultSrcW resets to 00 and ALUResultW resets to 0.
- E to M capture, on each rising clk when reset = 0 and StallM = 0:
  - FlushM = 1: M is loaded with a bubble. ValidM, RegWriteM and MemWriteM go to 0, RdM goes to 0 and ResultSrcM goes to 00. Data fields are don't-care; implement them as hold.
  - Otherwise: all E fields are latched.
    - ValidM is set to ValidE.
    - RegWriteM is set to RegWriteE & ValidE & (RdE != 0).
    - MemWriteM is set to MemWriteE & ValidE.
- M hold, when StallM = 1:
  - The M register holds all fields. StallM has priority over FlushM.
  - The W register loads a bubble: ValidW = 0, RegWriteW = 0, RdW = 0. This prevents a duplicate write and false forwarding.
- M to W capture, when StallM = 0:
  - W latches ValidM, RegWriteM, RdM, ResultSrcM, ALUResultM, PCPlus4M and ReadDataM into ReadDataW.
  - Read data is registered at the M/W boundary, so there is no combinational path from the data memory into W.
- ResultW, combinational from W registers:
  - 00 selects ALUResultW, 01 selects ReadDataW, 10 selects PCPlus4W, 11 selects 0.
- Latency:
  - An instruction present in E at edge n appears in M after edge n and in W after edge n+1, with no stalls.
  - Each StallM cycle adds one cycle.
- Register file write:
  - The write occurs while RegWriteW = 1. The register file writes on the falling edge, as elsewhere in the core.
  - x0 is never written, because RegWriteM is gated by RdE != 0.
- RetiredCount:
  - Increments by 1 on each rising edge where ValidW = 1 and reset = 0.
  - Wraps modulo 2^CNT_W, with no saturation.
- Reset mid-operation:
  - Reset overrides stall and flush, and clears both stages on the same edge.
  - Instructions in flight are lost and RetiredCount returns to 0.
- Simultaneous StallM and FlushM: stall wins. Any flush must be reasserted by the controller after the stall releases.
- Timing: no combinational path from any input to any output, except ReadDataM, which is registered only.

Test Plan:
1. Single add x5 (ValidE=1, RegWriteE=1, RdE=5, ALUResultE=0x00000010, ResultSrcE=00):
   - After edge 1: RdM=5, RegWriteM=1.
   - After edge 2: RdW=5, RegWriteW=1, ResultW=0x00000010.
   - After edge 3: RetiredCount=1.
2. Load (ResultSrcE=01, RdE=7) with ReadDataM=0xDEADBEEF during its M cycle:
   - Next cycle: ResultW=0xDEADBEEF, RegWriteW=1.
   - jal (ResultSrcE=10, PCPlus4E=0x104): ResultW=0x00000104.
3. Write to x0 (RegWriteE=1, RdE=0): RegWriteM=0 and RegWriteW=0, with ValidW=1 and the retired count incremented.
4. StallM held 2 cycles with add x3 in M:
   - RdM=3 and RegWriteM=1 hold for both cycles.
   - RegWriteW=0 during the stall.
   - The instruction reaches W exactly once, one cycle after the stall releases.
   - RetiredCount increases by exactly 1 for it.
5. FlushM with store in E (MemWriteE=1): MemWriteM=0, ValidM=0 and RdM=0 next cycle. StallM=FlushM=1 on the same edge: M holds with no bubble.
6. Reset asserted for one cycle while M and W are both valid:
   - Next cycle: all outputs are 0.
   - Counter preset near wrap (drive 2^CNT_W−1 retirements, or use a small CNT_W=4 variant): the next retirement wraps it to 0.
